mul_div_unit: RTL and testbench

Iterative, parametrised multiply/divide unit owning the HI/LO register pair for the MIPS core. It replaces single-cycle HI/LO arithmetic in the execute stage with a multi-cycle shift-add/restoring-divide datapath. A busy/done handshake lets the pipeline stall MFHI/MFLO and back-to-back HI/LO ops. A flush input lets exceptions and branch squashes abort an in-flight operation.

---
 rtl/mul_div_pkg.sv | 20 ++
 rtl/mul_div_unit.sv | 211 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states and
// the step-counter width helper.
package mul_div_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    function automatic int unsigned cnt_width(input int unsigned xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply and restoring divide.
// Optional MUL_DIV_EARLY_OUT_EN shortens multiplies with small multipliers and divides by zero.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs,
    input  logic [XLEN-1:0] rt,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned     CntW   = cnt_width(XLEN);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [CntW-1:0] CntTop = CntW'(XLEN - 1);
`ifdef MUL_DIV_EARLY_OUT_EN
    localparam bit              EarlyOut = 1'b1;
    localparam logic [XLEN-1:0] One      = XLEN'(1);
`else
    localparam bit              EarlyOut = 1'b0;
`endif

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] acc_hi_q, acc_hi_d;  // product upper half / partial remainder
    logic [XLEN-1:0] acc_lo_q, acc_lo_d;  // multiplier+product lower half / dividend+quotient
    logic [XLEN-1:0] opb_q, opb_d;        // multiplicand / divisor magnitude
    logic            is_div_q, is_div_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            div0_q, div0_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            done_q, done_d;

    logic            op_mul, op_div, op_signed, rs_neg, rt_neg, div0_now;
    logic [XLEN-1:0] rs_mag, rt_mag;

    logic [XLEN:0]   add_a, add_b;
    logic            add_cin;
    logic [XLEN+1:0] add_sum;
    logic            no_borrow;

    logic            mul_done_early;
    logic [2*XLEN-1:0] prod_full, prod_res;
    logic [XLEN-1:0] quo_res, rem_res;

    always_comb begin
        op_mul    = (op == OP_MULT) || (op == OP_MULTU);
        op_div    = (op == OP_DIV) || (op == OP_DIVU);
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        rs_neg    = op_signed && rs[XLEN-1];
        rt_neg    = op_signed && rt[XLEN-1];
        rs_mag    = rs_neg ? -rs : rs;
        rt_mag    = rt_neg ? -rt : rt;
        div0_now  = op_div && (rt == '0);
    end

    // Single XLEN+1-bit adder: accumulate for multiply, trial-subtract for divide.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == ST_CALC) begin
            if (is_div_q) begin
                add_a   = {acc_hi_q, acc_lo_q[XLEN-1]};
                add_b   = ~{1'b0, opb_q};
                add_cin = 1'b1;
            end else begin
                add_a = {1'b0, acc_hi_q};
                add_b = acc_lo_q[0] ? {1'b0, opb_q} : '0;
            end
        end
        add_sum   = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, add_cin};
        no_borrow = add_sum[XLEN+1];
    end

`ifdef MUL_DIV_EARLY_OUT_EN
    logic [XLEN-1:0] rest_mask;
    // Multiplier bits still unconsumed after this step sit in acc_lo_q[cnt_q:1].
    assign rest_mask      = (One << cnt_q) - One;
    assign mul_done_early = !is_div_q && (((acc_lo_q >> 1) & rest_mask) == '0);
    // Skipped steps would only have shifted right; apply them in one go.
    assign prod_full      = {acc_hi_q, acc_lo_q} >> cnt_q;
`else
    assign mul_done_early = 1'b0;
    assign prod_full      = {acc_hi_q, acc_lo_q};
`endif

    always_comb begin
        prod_res = neg_res_q ? -prod_full : prod_full;
        quo_res  = div0_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
        rem_res  = neg_rem_q ? -acc_hi_q : acc_hi_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            hi_d = rs;
                        end else if (op == OP_MTLO) begin
                            lo_d = rs;
                        end else if (op_mul || op_div) begin
                            acc_hi_d  = '0;
                            acc_lo_d  = op_div ? rs_mag : rt_mag;
                            opb_d     = op_div ? rt_mag : rs_mag;
                            is_div_d  = op_div;
                            neg_res_d = rs_neg ^ rt_neg;
                            neg_rem_d = rs_neg;
                            div0_d    = div0_now;
                            cnt_d     = CntTop;
                            state_d   = ST_CALC;
                            if (EarlyOut && div0_now) begin
                                acc_hi_d = rs_mag;
                                state_d  = ST_FIX;
                            end
                        end
                    end
                end
                ST_CALC: begin
                    if (is_div_q) begin
                        acc_hi_d = no_borrow ? add_sum[XLEN-1:0] : add_a[XLEN-1:0];
                        acc_lo_d = {acc_lo_q[XLEN-2:0], no_borrow};
                    end else begin
                        acc_hi_d = add_sum[XLEN:1];
                        acc_lo_d = {add_sum[0], acc_lo_q[XLEN-1:1]};
                    end
                    // cnt_q is kept on exit: it is the number of skipped multiply shifts.
                    if ((cnt_q == '0) || mul_done_early) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                ST_FIX: begin
                    if (is_div_q) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end else begin
                        hi_d = prod_res[2*XLEN-1:XLEN];
                        lo_d = prod_res[XLEN-1:0];
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed MULT/DIV vectors, HI/LO moves, busy, flush, reset.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    localparam int unsigned XLEN = 32;
`ifdef MUL_DIV_EARLY_OUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      op = 3'd0;
    logic [XLEN-1:0] rs = '0;
    logic [XLEN-1:0] rt = '0;
    logic            flush = 1'b0;
    logic            busy, done;
    logic [XLEN-1:0] hi, lo;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] b);
        logic [31:0] m;
        int          k;
        m = (o == OP_MULT && b[31]) ? -b : b;
        k = 0;
        for (int i = 0; i < 32; i++) if (m[i]) k = i;
        if (EarlyOut && (o == OP_DIV || o == OP_DIVU) && b == '0) return 1;
        if (EarlyOut && (o == OP_MULT || o == OP_MULTU)) return k + 2;
        return XLEN + 1;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RST_N && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hi"}, hi, e.hi);
                check({e.name, "_lo"}, lo, e.lo);
                check_int({e.name, "_done_cycle"}, cyc, e.done_cyc);
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input bit push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge CLK);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_issue_timeout: got busy=%b, expected 0", name, busy);
        end
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(posedge CLK);
        #1;
        start = 1'b0;
        if (push) begin
            e.name     = name;
            e.hi       = eh;
            e.lo       = el;
            e.done_cyc = cyc + exp_lat(o, b);
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout: got %0d pending, expected 0", name, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        RST_N = 1'b1;

        // HI/LO moves take effect at the accepting edge without going busy.
        @(negedge CLK);
        start = 1'b1; op = OP_MTHI; rs = 32'h1234_5678;
        @(posedge CLK); #1;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", 32'(busy), 32'h0);
        op = OP_MTLO; rs = 32'hCAFE_F00D;
        @(posedge CLK); #1;
        check("mtlo_lo", lo, 32'hCAFE_F00D);
        check("mtlo_hi_kept", hi, 32'h1234_5678);
        op = 3'd7; rs = 32'h5555_5555;
        @(posedge CLK); #1;
        start = 1'b0;
        check("unknown_busy", 32'(busy), 32'h0);
        check("unknown_hi", hi, 32'h1234_5678);
        check("unknown_lo", lo, 32'hCAFE_F00D);
        @(posedge CLK); #1;
        check("move_no_done", 32'(done), 32'h0);

        // Back-to-back: each issue lands in the done cycle of the previous op.
        issue("mult_neg3x5",   OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005,
              32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);
        issue("multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        issue("div_neg7by2",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        issue("div_minbym1",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,
              32'h0000_0000, 32'h8000_0000, 1'b1);
        issue("divu_by0",      OP_DIVU,  32'h0000_0005, 32'h0000_0000,
              32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        issue("div_neg_by0",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000,
              32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        issue("mult_7xneg2",   OP_MULT,  32'h0000_0007, 32'hFFFF_FFFE,
              32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b1);
        issue("divu_100by7",   OP_DIVU,  32'h0000_0064, 32'h0000_0007,
              32'h0000_0002, 32'h0000_000E, 1'b1);
        issue("div_7byneg2",   OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE,
              32'h0000_0001, 32'hFFFF_FFFD, 1'b1);
        issue("multu_2p16sq",  OP_MULTU, 32'h0001_0000, 32'h0001_0000,
              32'h0000_0001, 32'h0000_0000, 1'b1);
        issue("mult_by0",      OP_MULT,  32'h1234_5678, 32'h0000_0000,
              32'h0000_0000, 32'h0000_0000, 1'b1);
        wait_idle("vectors");

        // Starts while busy are dropped, not queued.
        issue("multu_3x3", OP_MULTU, 32'h0000_0003, 32'h0000_0003,
              32'h0000_0000, 32'h0000_0009, 1'b1);
        @(negedge CLK);
        start = 1'b1; op = OP_MTHI; rs = 32'hDEAD_BEEF;
        @(negedge CLK);
        op = OP_DIVU; rs = 32'h0000_0005; rt = 32'h0000_0000;
        @(negedge CLK);
        start = 1'b0;
        wait_idle("busy_start");
        check("busy_start_hi", hi, 32'h0000_0000);
        check("busy_start_lo", lo, 32'h0000_0009);
        check("busy_start_idle", 32'(busy), 32'h0);

        // Flush mid-multiply, with a competing start in the same cycle.
        issue("mult_flushed", OP_MULT, 32'h0000_0005, 32'h8000_0007, 32'h0, 32'h0, 1'b0);
        repeat (9) @(negedge CLK);
        flush = 1'b1;
        start = 1'b1; op = OP_MTLO; rs = 32'h1111_1111;
        @(posedge CLK); #1;
        check("flush_busy", 32'(busy), 32'h0);
        flush = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge CLK);
        check("flush_hi", hi, 32'h0000_0000);
        check("flush_lo", lo, 32'h0000_0009);
        check("flush_still_idle", 32'(busy), 32'h0);

        issue("divu_after_flush", OP_DIVU, 32'h0000_0064, 32'h0000_0007,
              32'h0000_0002, 32'h0000_000E, 1'b1);
        wait_idle("after_flush");

        // Asynchronous reset mid-operation clears everything without a clock edge.
        issue("mult_reset", OP_MULT, 32'hFFFF_FFFD, 32'h8000_0005, 32'h0, 32'h0, 1'b0);
        repeat (5) @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("amid_rst_hi", hi, 32'h0);
        check("amid_rst_lo", lo, 32'h0);
        check("amid_rst_busy", 32'(busy), 32'h0);
        check("amid_rst_done", 32'(done), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        issue("mult_after_rst", OP_MULT, 32'h0000_0007, 32'hFFFF_FFFE,
              32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b1);
        wait_idle("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
